inst_fetch_resp: RTL and testbench

Instruction-fetch responder that sits between the PC register and the instruction ROM. It accepts fetch requests carrying the PC and issues the ROM read. It returns each instruction with its PC through a small buffered response channel with valid/ready, in request order. A flush input discards everything in flight on branch redirect or exception.

---
 rtl/inst_fetch_resp_pkg.sv | 23 ++
 rtl/fetch_rsp_fifo.sv | 75 +++++++
 rtl/inst_fetch_resp.sv | 97 +++++++++
 tb/tb_inst_fetch_resp.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_resp_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// The response record travels through the buffer as one packed word.
package inst_fetch_resp_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord = '0;
    localparam logic [InstBus-1:0] NOP_INST = 32'h0;
    localparam logic               RstEnable = 1'b1;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
        logic                   exc;
    } fetch_rsp_t;

    // Size of the ROM in bytes, widened so a 2^30-word ROM does not overflow.
    function automatic logic [32:0] rom_bytes(input int aw);
        return 33'd1 << (aw + 2);
    endfunction

endpackage

// File: rtl/fetch_rsp_fifo.sv
// Synchronous FIFO with clear; clear wins over push and pop in the same cycle.
// Reset also zeroes the storage so the head reads as zero after reset.
module fetch_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 65,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        // A push into a full FIFO is only legal when the head leaves in the same cycle.
        do_push  = push && (!full || do_pop);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/inst_fetch_resp.sv
// Fetch responder: registers the request (S1), reads the 1-cycle ROM, and buffers
// {pc, inst, exc} for an in-order valid/ready consumer. Flush drops everything in flight.
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter int          ROM_AW     = 10,
    parameter logic [31:0] ROM_BASE   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [31:0]       req_pc,
    output logic              req_ready,
    input  logic              flush,
    output logic              rom_ce,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_pc,
    output logic [31:0]       rsp_inst,
    output logic              rsp_exc,
    input  logic              rsp_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          s1_valid_q, s1_valid_d;
    logic [31:0]   s1_pc_q, s1_pc_d;
    logic          s1_exc_q, s1_exc_d;
    logic [31:0]   rel_pc;
    logic          req_exc;
    logic          accept;
    logic          rsp_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_rsp_t    push_data;
    fetch_rsp_t    head;

    assign rsp_valid = !fifo_empty;
    assign rsp_pc    = head.pc;
    assign rsp_inst  = head.inst;
    assign rsp_exc   = head.exc;

    always_comb begin
        rel_pc  = req_pc - ROM_BASE;
        req_exc = (req_pc[1:0] != 2'b00) || ({1'b0, rel_pc} >= rom_bytes(ROM_AW));
        rsp_pop = rsp_valid && rsp_ready;
        // Credit counts the fetch in S1; a pop this cycle frees a slot for it.
        req_ready = (rst != RstEnable) && !flush &&
                    ((int'(fifo_count) + int'(s1_valid_q) < FIFO_DEPTH) || rsp_pop);
        accept   = req_valid && req_ready;
        rom_ce   = accept && !req_exc;
        rom_addr = rom_ce ? rel_pc[ROM_AW+1:2] : '0;

        s1_valid_d = accept;
        s1_pc_d    = accept ? req_pc  : s1_pc_q;
        s1_exc_d   = accept ? req_exc : s1_exc_q;

        push_data.pc   = s1_pc_q;
        push_data.inst = s1_exc_q ? NOP_INST : rom_rdata;
        push_data.exc  = s1_exc_q;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            s1_valid_q <= 1'b0;
            s1_pc_q    <= ZeroWord;
            s1_exc_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pc_q    <= s1_pc_d;
            s1_exc_q   <= s1_exc_d;
        end
    end

    fetch_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fetch_rsp_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (s1_valid_q),
        .wdata (push_data),
        .pop   (rsp_pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    push_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(s1_valid_q && fifo_full && !rsp_pop && !flush));

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: directed scenarios plus random traffic, checked by
// an expected-response queue filled at request handshake and drained by a monitor.
module tb_inst_fetch_resp;

    localparam int ROM_AW = 10;
    localparam int ROM_WORDS = 1 << ROM_AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [31:0]       req_pc;
    logic              req_ready;
    logic              flush;
    logic              rom_ce;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_rdata;
    logic              rsp_valid;
    logic [31:0]       rsp_pc;
    logic [31:0]       rsp_inst;
    logic              rsp_exc;
    logic              rsp_ready;

    logic [31:0] rom_mem [ROM_WORDS];
    logic [64:0] exp_q [$];
    int          acc_cyc [$];
    int          pop_cyc [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          n_pops = 0;
    int          n0;
    logic        prev_hold = 1'b0;
    logic [64:0] prev_rsp;

    inst_fetch_resp #(
        .ROM_AW     (ROM_AW),
        .ROM_BASE   (32'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_pc    (req_pc),
        .req_ready (req_ready),
        .flush     (flush),
        .rom_ce    (rom_ce),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .rsp_valid (rsp_valid),
        .rsp_pc    (rsp_pc),
        .rsp_inst  (rsp_inst),
        .rsp_exc   (rsp_exc),
        .rsp_ready (rsp_ready)
    );

    // ---------------- clock / ROM model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rom_rdata <= rom_ce ? rom_mem[rom_addr] : $urandom;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [64:0] model_rsp(input logic [31:0] pc);
        logic        exc;
        logic [31:0] inst;
        exc  = (pc % 4 != 0) || (pc >= 32'(ROM_WORDS * 4));
        inst = exc ? 32'h0 : rom_mem[pc / 4];
        return {pc, inst, exc};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [64:0] got;
        logic [64:0] e;
        got = {rsp_pc, rsp_inst, rsp_exc};
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("rsp_stable_valid", rsp_valid, 1);
                chk("rsp_stable_data", got, prev_rsp);
            end
            if (rsp_valid && rsp_ready) begin
                n_pops++;
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rsp_unexpected: got pc %0h inst %0h exc %0b, expected no response",
                             rsp_pc, rsp_inst, rsp_exc);
                end else begin
                    chk("rsp_payload", got, exp_q.pop_front());
                end
            end
            if (flush) begin
                chk("flush_req_ready", req_ready, 0);
                chk("flush_rom_ce", rom_ce, 0);
                exp_q.delete();
            end
            if (req_valid && req_ready) begin
                e = model_rsp(req_pc);
                chk("rom_ce", rom_ce, !e[0]);
                if (!e[0]) chk("rom_addr", rom_addr, ROM_AW'(req_pc >> 2));
                exp_q.push_back(e);
                acc_cyc.push_back(cyc);
            end else begin
                chk("rom_ce_idle", rom_ce, 0);
            end
            prev_hold = rsp_valid && !rsp_ready && !flush;
            prev_rsp  = got;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] pc);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_pc    = pc;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL req_timeout: pc %0h not accepted, expected accept within 20 cycles", pc);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        flush     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || rsp_valid) && n < 40) begin
            n++;
            step(1);
        end
        step(1);
        chk("drain_left", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = $urandom;
        rom_mem[0] = 32'h11;
        rom_mem[1] = 32'h12;
        rom_mem[2] = 32'h13;
        rom_mem[3] = 32'h14;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_pc    = 32'h0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        step(2);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rom_ce", rom_ce, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_pc", rsp_pc, 0);
        chk("rst_rsp_inst", rsp_inst, 0);
        chk("rst_rsp_exc", rsp_exc, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1);

        // back-to-back fetches
        rsp_ready = 1'b1;
        acc_cyc.delete();
        pop_cyc.delete();
        for (int i = 0; i < 4; i++) send(32'(i * 4));
        step(4);
        chk("b2b_count", pop_cyc.size(), 4);
        if (pop_cyc.size() >= 4 && acc_cyc.size() >= 4) begin
            chk("b2b_latency", pop_cyc[0] - acc_cyc[0], 2);
            for (int i = 1; i < 4; i++) begin
                chk("b2b_accept_consec", acc_cyc[i] - acc_cyc[i-1], 1);
                chk("b2b_rsp_consec", pop_cyc[i] - pop_cyc[i-1], 1);
            end
        end

        // backpressure
        rsp_ready = 1'b0;
        n0 = n_pops;
        send(32'h0);
        send(32'h4);
        req_valid = 1'b1;
        req_pc    = 32'h8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready_low", req_ready, 0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_on_pop", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drain();
        chk("bp_pops", n_pops - n0, 3);

        // exceptions and range boundaries
        rsp_ready = 1'b1;
        send(32'h6);
        send(32'h1000);
        send(32'hFFC);
        send(32'h3);
        send(32'hFFFF_FFFC);
        drain();

        // flush mid-flight
        rsp_ready = 1'b0;
        send(32'h0);
        send(32'h4);
        n0 = n_pops;
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        step(3);
        chk("flush_no_rsp", n_pops - n0, 0);
        send(32'h40);
        drain();

        // reset mid-stream
        rsp_ready = 1'b0;
        send(32'h8);
        send(32'hC);
        step(1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_req_ready", req_ready, 0);
        chk("mrst_rom_ce", rom_ce, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_rsp_valid", rsp_valid, 0);
        chk("mrst_rsp_pc", rsp_pc, 0);
        chk("mrst_rsp_inst", rsp_inst, 0);
        chk("mrst_rsp_exc", rsp_exc, 0);
        chk("mrst_rom_addr", rom_addr, 0);
        @(posedge clk);
        #1;
        n0 = n_pops;
        rsp_ready = 1'b1;
        step(3);
        chk("mrst_no_stale", n_pops - n0, 0);

        // flush together with a pop
        rsp_ready = 1'b0;
        send(32'h10);
        send(32'h14);
        step(1);
        n0 = n_pops;
        flush     = 1'b1;
        rsp_ready = 1'b1;
        step(1);
        flush = 1'b0;
        @(negedge clk);
        chk("fp_empty", rsp_valid, 0);
        @(posedge clk);
        #1;
        step(2);
        chk("fp_one_pop", n_pops - n0, 1);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 9);
            req_valid = ($urandom_range(0, 3) != 0);
            if (r < 7)       req_pc = {20'h0, 10'($urandom_range(0, ROM_WORDS - 1)), 2'b00};
            else if (r == 7) req_pc = {20'h0, 10'($urandom_range(0, ROM_WORDS - 1)), 2'($urandom_range(1, 3))};
            else if (r == 8) req_pc = $urandom | 32'h0000_1000;
            else             req_pc = ($urandom_range(0, 1) != 0) ? 32'hFFC : 32'h1000;
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            step(1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
